// File: rtl/pipe_stall_ctrl_pkg.sv
// rtl/pipe_stall_ctrl_pkg.sv - shared constants, state codes and stall-mask helper for the stall sequencer
package pipe_stall_ctrl_pkg;

    localparam int STALL_WD = 8;

    // Pipeline stage indices
    localparam int STG_PC   = 0;
    localparam int STG_IF1  = 1;
    localparam int STG_IF2  = 2;
    localparam int STG_ID   = 3;
    localparam int STG_EX   = 4;
    localparam int STG_MEM1 = 5;
    localparam int STG_MEM2 = 6;
    localparam int STG_WB   = 7;

    typedef enum logic {
        CTRL_IDLE = 1'b0,
        CTRL_MC   = 1'b1
    } ctrl_state_e;

    localparam logic [STALL_WD-1:0] CTRL_FLUSH_BR  = 8'h0F;
    localparam logic [STALL_WD-1:0] CTRL_FLUSH_EXC = 8'h7F;

    // Thermometer mask holding stages 0..deepest
    function automatic logic [STALL_WD-1:0] stall_mask(input int deepest);
        logic [STALL_WD-1:0] m;
        for (int i = 0; i < STALL_WD; i++) begin
            m[i] = (i <= deepest);
        end
        return m;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - request/response bundle between the pipeline and the stall sequencer
interface pipe_stall_ctrl_if #(
    parameter int PC_W = 32,
    parameter int MC_W = 6
);
    // Requests from the pipeline
    logic            stallreq_if;
    logic            stallreq_id;
    logic            ex_mc_start;
    logic [MC_W-1:0] ex_mc_len;
    logic            stallreq_mem;
    logic            br_flush_req;
    logic [PC_W-1:0] br_target;
    logic            exc_req;
    logic [PC_W-1:0] exc_pc;

    // Controls back to the pipeline
    logic [7:0]      stall;
    logic [7:0]      flush;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            stall_timeout;

    // Pipeline side
    modport master (
        output stallreq_if, stallreq_id, ex_mc_start, ex_mc_len, stallreq_mem,
               br_flush_req, br_target, exc_req, exc_pc,
        input  stall, flush, redirect_valid, redirect_pc, stall_timeout
    );

    // Sequencer side
    modport slave (
        input  stallreq_if, stallreq_id, ex_mc_start, ex_mc_len, stallreq_mem,
               br_flush_req, br_target, exc_req, exc_pc,
        output stall, flush, redirect_valid, redirect_pc, stall_timeout
    );

endinterface

// File: rtl/pipe_stall_ctrl_stall_wdog.sv
// rtl/pipe_stall_ctrl_stall_wdog.sv - saturating consecutive-stall counter with sticky timeout flag
module stall_wdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_i,
    output logic timeout_o
);
    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    // Count consecutive stalled cycles, saturate at the limit, latch the flag once reached
    always_comb begin
        cnt_d = cnt_q;
        if (!stall_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT_C) begin
            cnt_d = cnt_q + CW'(1);
        end
        timeout_d = timeout_q | (cnt_d == LIMIT_C);
    end

    // Counter and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - stall vector, multi-cycle sequencing, flush and PC redirect for the 8-stage pipeline
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int PC_W       = 32,
    parameter int MC_W       = 6,
    parameter int WDOG_LIMIT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stall_ctrl_if.slave ctrl_if
);
    ctrl_state_e         state_q, state_d;
    logic [MC_W-1:0]     mc_cnt_q, mc_cnt_d;
    logic                pend_valid_q, pend_valid_d;
    logic [PC_W-1:0]     pend_pc_q, pend_pc_d;

    logic                live;
    logic                mc_len_nz;
    logic                ex_mc_active;
    logic [STALL_WD-1:0] stall_v;
    logic [STALL_WD-1:0] flush_v;
    logic                redirect_valid_v;
    logic [PC_W-1:0]     redirect_pc_v;
    logic                exc_take;
    logic                br_pend_take;
    logic                br_live_take;
    logic                br_latch;
    logic                timeout_w;

    // Every combinational output is forced low while reset is asserted
    assign live         = !rst;
    assign mc_len_nz    = (ctrl_if.ex_mc_len != '0);
    assign ex_mc_active = (state_q == CTRL_MC) || (ctrl_if.ex_mc_start && mc_len_nz);

    // Deepest active stall source sets the thermometer boundary; WB is never held
    always_comb begin
        stall_v = '0;
        if (!live) begin
            stall_v = '0;
        end else if (ctrl_if.stallreq_mem) begin
            stall_v = stall_mask(STG_MEM2);
        end else if (ex_mc_active) begin
            stall_v = stall_mask(STG_EX);
        end else if (ctrl_if.stallreq_id) begin
            stall_v = stall_mask(STG_ID);
        end else if (ctrl_if.stallreq_if) begin
            stall_v = stall_mask(STG_IF1);
        end
    end

    // A held EX stage means the branch cannot retire yet; a held MEM2 blocks the exception
    assign exc_take     = live && ctrl_if.exc_req && !stall_v[STG_MEM2];
    assign br_pend_take = live && pend_valid_q && !stall_v[STG_EX];
    assign br_live_take = live && ctrl_if.br_flush_req && !pend_valid_q && !stall_v[STG_EX];
    assign br_latch     = live && ctrl_if.br_flush_req && !pend_valid_q && stall_v[STG_EX];

    // State, multi-cycle counter and pending-branch registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= CTRL_IDLE;
            mc_cnt_q     <= '0;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            mc_cnt_q     <= mc_cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    // Next state: the start cycle counts as the first stall cycle, so MC covers the remaining N-1
    always_comb begin
        state_d      = state_q;
        mc_cnt_d     = mc_cnt_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;

        case (state_q)
            CTRL_IDLE: begin
                if (ctrl_if.ex_mc_start && mc_len_nz) begin
                    mc_cnt_d = ctrl_if.ex_mc_len - MC_W'(1);
                    state_d  = (ctrl_if.ex_mc_len == MC_W'(1)) ? CTRL_IDLE : CTRL_MC;
                end
            end
            CTRL_MC: begin
                mc_cnt_d = mc_cnt_q - MC_W'(1);
                if (mc_cnt_q <= MC_W'(1)) begin
                    state_d  = CTRL_IDLE;
                    mc_cnt_d = '0;
                end
            end
            default: begin
                state_d  = CTRL_IDLE;
                mc_cnt_d = '0;
            end
        endcase

        // A live request in the release cycle is the same branch as the pending one
        if (br_pend_take) begin
            pend_valid_d = 1'b0;
        end else if (br_latch) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = ctrl_if.br_target;
        end

        // An exception kills everything younger, including any multi-cycle op and pending branch
        if (exc_take) begin
            state_d      = CTRL_IDLE;
            mc_cnt_d     = '0;
            pend_valid_d = 1'b0;
        end
    end

    // Flush and redirect outputs; exception outranks both branch sources
    always_comb begin
        flush_v          = '0;
        redirect_valid_v = 1'b0;
        redirect_pc_v    = '0;
        if (exc_take) begin
            flush_v          = CTRL_FLUSH_EXC;
            redirect_valid_v = 1'b1;
            redirect_pc_v    = ctrl_if.exc_pc;
        end else if (br_pend_take) begin
            flush_v          = CTRL_FLUSH_BR;
            redirect_valid_v = 1'b1;
            redirect_pc_v    = pend_pc_q;
        end else if (br_live_take) begin
            flush_v          = CTRL_FLUSH_BR;
            redirect_valid_v = 1'b1;
            redirect_pc_v    = ctrl_if.br_target;
        end
    end

    stall_wdog #(
        .LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .stall_i   (stall_v[STG_PC]),
        .timeout_o (timeout_w)
    );

    assign ctrl_if.stall          = stall_v;
    assign ctrl_if.flush          = flush_v;
    assign ctrl_if.redirect_valid = redirect_valid_v;
    assign ctrl_if.redirect_pc    = redirect_pc_v;
    assign ctrl_if.stall_timeout  = timeout_w;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - randomized and directed self-checking bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;
    localparam int LIMIT = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl_if #(.PC_W(32), .MC_W(6)) bus ();

    pipe_stall_ctrl #(
        .PC_W       (32),
        .MC_W       (6),
        .WDOG_LIMIT (LIMIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_if (bus)
    );

    // Reference model: remaining multi-cycle stall cycles, pending branch, consecutive stall run
    int          m_mc_left;
    bit          m_pend;
    logic [31:0] m_pend_pc;
    int          m_run;
    bit          m_tmo;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mc_left = 0;
        m_pend    = 0;
        m_pend_pc = '0;
        m_run     = 0;
        m_tmo     = 0;
    endtask

    task automatic model_eval(output logic [7:0] s, output logic [7:0] f,
                              output logic rv, output logic [31:0] pc);
        int deep;
        deep = -1;
        if (bus.stallreq_if) deep = 1;
        if (bus.stallreq_id) deep = 3;
        if (m_mc_left > 0 || (bus.ex_mc_start && bus.ex_mc_len != 0)) deep = 4;
        if (bus.stallreq_mem) deep = 6;
        s  = (deep < 0) ? 8'h00 : 8'((1 << (deep + 1)) - 1);
        f  = 8'h00;
        rv = 1'b0;
        pc = '0;
        if (bus.exc_req && !s[6]) begin
            f = 8'h7F; rv = 1'b1; pc = bus.exc_pc;
        end else if (m_pend && !s[4]) begin
            f = 8'h0F; rv = 1'b1; pc = m_pend_pc;
        end else if (bus.br_flush_req && !s[4]) begin
            f = 8'h0F; rv = 1'b1; pc = bus.br_target;
        end
    endtask

    task automatic model_step(input logic [7:0] s);
        if (bus.exc_req && !s[6]) begin
            m_mc_left = 0;
            m_pend    = 0;
        end else begin
            if (m_mc_left > 0) m_mc_left--;
            else if (bus.ex_mc_start && bus.ex_mc_len != 0) m_mc_left = int'(bus.ex_mc_len) - 1;
            if (m_pend && !s[4]) m_pend = 0;
            else if (!m_pend && bus.br_flush_req && s[4]) begin
                m_pend    = 1;
                m_pend_pc = bus.br_target;
            end
        end
        if (s[0]) m_run = (m_run < LIMIT) ? m_run + 1 : LIMIT;
        else m_run = 0;
        if (m_run >= LIMIT) m_tmo = 1;
    endtask

    task automatic drive(input bit sif, input bit sid, input bit smem, input bit st, input int len,
                         input bit br, input logic [31:0] bt, input bit ex, input logic [31:0] ep);
        bus.stallreq_if  = sif;
        bus.stallreq_id  = sid;
        bus.stallreq_mem = smem;
        bus.ex_mc_start  = st;
        bus.ex_mc_len    = 6'(len);
        bus.br_flush_req = br;
        bus.br_target    = bt;
        bus.exc_req      = ex;
        bus.exc_pc       = ep;
    endtask

    // Called just after a falling edge with inputs driven; xs/xrv/xpc are directed constants (-1 skips)
    task automatic step(input int xs, input int xrv, input logic [31:0] xpc);
        logic [7:0]  es, ef;
        logic        erv;
        logic [31:0] epc;
        #2;
        if (rst) model_reset();
        model_eval(es, ef, erv, epc);
        if (rst) begin
            es = 8'h00; ef = 8'h00; erv = 1'b0;
        end
        check_eq("stall", 32'(bus.stall), 32'(es));
        check_eq("flush", 32'(bus.flush), 32'(ef));
        check_eq("redirect_valid", 32'(bus.redirect_valid), 32'(erv));
        if (erv) check_eq("redirect_pc", bus.redirect_pc, epc);
        check_eq("stall_timeout", 32'(bus.stall_timeout), 32'(m_tmo));
        if (xs >= 0) check_eq("dir_stall", 32'(bus.stall), 32'(xs));
        if (xrv >= 0) check_eq("dir_redirect_valid", 32'(bus.redirect_valid), 32'(xrv));
        if (xrv == 1) check_eq("dir_redirect_pc", bus.redirect_pc, xpc);
        @(posedge clk);
        if (rst) model_reset();
        else model_step(es);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        rst = 1'b1;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        step(8'h00, 0, 0);
        rst = 1'b0;

        // IF miss for 3 cycles, then IF+ID
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step(8'h03, 0, 0);
        end
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0); step(8'h0F, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(8'h00, 0, 0);

        // Multi-cycle len 5, len 0, len 1
        drive(0, 0, 0, 1, 5, 0, 0, 0, 0); step(8'h1F, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(8'h1F, 0, 0);
        step(8'h00, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0); step(8'h00, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 0, 0, 0); step(8'h1F, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(8'h00, 0, 0);

        // Multi-cycle len 4 with a D-cache miss overlapping and outlasting it
        drive(0, 0, 0, 1, 4, 0, 0, 0, 0); step(8'h1F, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(8'h1F, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(8'h7F, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(8'h00, 0, 0);

        // Branch held during MEM stall, redirected when it drops
        drive(0, 0, 1, 0, 0, 1, 32'h8000_0100, 0, 0); step(8'h7F, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 32'h8000_0100, 0, 0); step(8'h00, 1, 32'h8000_0100);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(8'h00, 0, 0);

        // Exception during MC with a pending branch
        drive(0, 0, 0, 1, 6, 0, 0, 0, 0); step(8'h1F, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 32'h8000_0200, 0, 0); step(8'h1F, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 32'h8000_0200, 1, 32'h8000_0004); step(8'h1F, 1, 32'h8000_0004);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(8'h00, 0, 0);
        step(8'h00, 0, 0);

        // Watchdog: 8 consecutive stall cycles set the sticky flag
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(8'h03, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(8'h00, 0, 0);
        check_eq("wdog_sticky", 32'(bus.stall_timeout), 32'd1);

        // Reset asserted mid-MC with requests still high
        drive(0, 0, 0, 1, 6, 0, 0, 0, 0); step(8'h1F, 0, 0);
        drive(1, 1, 1, 0, 0, 1, 32'h1234_5678, 1, 32'h0000_0040);
        rst = 1'b1;
        step(8'h00, 0, 0);
        check_eq("rst_timeout", 32'(bus.stall_timeout), 32'd0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(8'h00, 0, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0, int'($urandom_range(0, 7)),
                  $urandom_range(0, 5) == 0, $urandom, $urandom_range(0, 19) == 0, $urandom);
            rst = ($urandom_range(0, 299) == 0);
            step(-1, -1, 0);
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush sequencer for the 8-stage in-order RV32 pipeline: PC(0) IF1(1) IF2(2) ID(3) EX(4) MEM1(5) MEM2(6) WB(7).
- Combines stall requests from IF, ID, EX multi-cycle units and MEM into the shared thermometer stall vector consumed by every pipeline register, including the WB input register.
- Sequences EX multi-cycle operations with a countdown and issues flush vectors and PC redirects for branch mispredicts and MEM2-committed exceptions.
- Holds a pending-branch register and a stall watchdog.

Parameters:
- PC_W, 32, redirect PC width.
- MC_W, 6, width of the multi-cycle length and counter.
- WDOG_LIMIT, 1024, consecutive stall[0] cycles before stall_timeout sets.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- stallreq_if  in  1  level; I-cache miss.
- stallreq_id  in  1  level; load-use hazard.
- ex_mc_start  in  1  pulse; EX multi-cycle op (div) issued.
- ex_mc_len  in  MC_W  cycle count for ex_mc_start.
- stallreq_mem  in  1  level; D-cache miss, data due in MEM2.
- br_flush_req  in  1  EX branch mispredict; held by EX while EX is stalled.
- br_target  in  PC_W  corrected PC.
- exc_req  in  1  exception at MEM2 commit point.
- exc_pc  in  PC_W  trap vector.
- stall  out  8  stall[k]=1 holds stage k; register k→k+1 loads a bubble when stall[k]&!stall[k+1].
- flush  out  8  flush[k]=1 clears register k→k+1 this cycle.
- redirect_valid  out  1  PC must load redirect_pc.
- redirect_pc  out  PC_W  new fetch PC.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, rst=1): state=IDLE, mc_cnt=0, pend_valid=0, pend_pc=0, wdog_cnt=0, stall_timeout=0. All combinational outputs evaluate to 0 while in reset.
- Stall vector: combinational, same cycle as the requests. k = deepest active source: mem→6, ex_mc_active→4, id→3, if→1. stall = (1<<(k+1))-1. No source active → 8'h00. stall[7] is always 0.
- ex_mc_active = (state==MC) | (ex_mc_start & ex_mc_len!=0).
- FSM IDLE:
  - ex_mc_start with len N≥1 → MC, mc_cnt=N-1. If N==1, return to IDLE next cycle.
  - len==0 → no stall, stay IDLE.
- FSM MC:
  - Decrement mc_cnt each cycle, regardless of deeper stalls.
  - mc_cnt==0 → IDLE. Stall[4:0] is held exactly N cycles, counting the start cycle.
  - ex_mc_start while in MC is ignored.
- Branch:
  - br_flush_req & !stall[4] → flush=8'h0F, redirect_valid=1, redirect_pc=br_target, same cycle.
  - br_flush_req & stall[4] & !pend_valid → latch pend_valid=1, pend_pc=br_target.
  - First cycle with pend_valid & !stall[4] → issue the redirect from pend_pc, clear pend_valid.
  - A live br_flush_req in that cycle is the same branch; pend_pc wins.
- Exception:
  - exc_req & !stall[6] → flush=8'h7F, redirect_valid=1, redirect_pc=exc_pc.
  - It also clears pend_valid, forces state to IDLE with mc_cnt=0, and overrides any branch redirect that cycle.
  - exc_req with stall[6]=1 is ignored; the requester holds it.
- Flush/stall interaction: in a flush cycle, stall bits from sources younger than the flushing stage still apply. Flushed registers clear regardless of stall.
- Watchdog:
  - wdog_cnt increments while stall[0]=1 and clears when stall[0]=0.
  - Saturates at WDOG_LIMIT.
  - On reaching WDOG_LIMIT, stall_timeout sets and stays set until rst.

Decomposition:
- define.vh gains STALL_WD=8, stage indices (STG_PC..STG_WB), CTRL_IDLE/CTRL_MC state codes, and CTRL_FLUSH_BR=8'h0F, CTRL_FLUSH_EXC=8'h7F.
- One sub-module, stall_wdog (saturating counter plus sticky flag). Everything else stays in pipe_stall_ctrl.

Test Plan:
- stallreq_if=1 for 3 cycles → stall=8'h03 for exactly those cycles, flush=0; stallreq_if with stallreq_id → 8'h0F.
- ex_mc_start, len=5 → stall=8'h1F for 5 cycles starting at the start cycle, then 8'h00. len=0 → no stall. len=1 → exactly 1 cycle.
- MC active (len=4) and stallreq_mem in cycle 2 → stall=8'h7F while mem is high. MC still ends after 4 total cycles; stall falls to 8'h00 only when mem drops.
- br_flush_req with target 0x8000_0100 during stallreq_mem=1 → no redirect. When mem drops: redirect_valid=1, redirect_pc=0x8000_0100, flush=8'h0F for one cycle.
- exc_req with exc_pc 0x8000_0004 during MC and pending branch → flush=8'h7F, redirect to 0x8000_0004; next cycle state=IDLE, pend_valid=0, stall=8'h00.
- WDOG_LIMIT=8 override, stallreq_if held 8 cycles → stall_timeout=1 at cycle 8 and stays 1 after the request drops. rst pulse mid-MC → all outputs 0 immediately.
